number_convert_arbiter: RTL and testbench
=========================================

NUMBER_CONVERT_ARBITER -- requirements
Module: number_convert_arbiter

Interface
REQ-001 SHALL have parameter DATA_W, default 32, operand/result width.
REQ-002 SHALL have parameter WAIT_CYC, default 1, cycles operands are held on the converter before capture; a value of 0 SHALL behave as 1.
REQ-003 SHALL have port clk  in  1  sole clock, rising edge.
REQ-004 SHALL have port rst  in  1  synchronous, active-high reset.
REQ-005 SHALL have ports req0_valid / req1_valid  in  1  requester n has an operand.
REQ-006 SHALL have ports req0_ready / req1_ready  out  1  requester n accepted this cycle.
REQ-007 SHALL have ports req0_data / req1_data  in  DATA_W  operand.
REQ-008 SHALL have ports req0_to_float / req1_to_float  in  1  1 = Q16.16 to float, 0 = float to Q16.16.
REQ-009 SHALL have ports rsp0_valid / rsp1_valid  out  1  result for requester n.
REQ-010 SHALL have ports rsp0_ready / rsp1_ready  in  1  requester n takes the result.
REQ-011 SHALL have port rsp_data  out  DATA_W  result, shared by both requesters.
REQ-012 SHALL have ports conv_data_in  out  DATA_W, conv_to_float  out  1, conv_data_out  in  DATA_W  drive and return of the number converter.
REQ-013 SHALL have port busy  out  1  high when the FSM is not in IDLE.
REQ-014 SHALL have port grant_id  out  1  requester owning the current or last transaction.
REQ-015 SHALL have port conv_count  out  16  completed-transaction counter.

Function
REQ-016 SHALL implement FSM states IDLE -> ISSUE -> RESPOND -> IDLE.
REQ-017 SHALL, in IDLE, assert req_ready combinationally only for the arbitration winner; no req_ready is asserted outside IDLE.
REQ-018 SHALL arbitrate round-robin: one valid request wins; with both valid, the requester not equal to last_grant wins.
REQ-019 SHALL, on an accept edge (valid && ready), register the operand, direction and grant_id, set last_grant, and enter ISSUE.
REQ-020 SHALL drive conv_data_in / conv_to_float from the registered operand, stable for the whole of ISSUE.
REQ-021 SHALL stay in ISSUE exactly WAIT_CYC cycles, then capture conv_data_out into rsp_data at the final ISSUE edge and enter RESPOND.
REQ-022 Latency: accept in cycle T gives rsp_valid first high in cycle T+1+WAIT_CYC (cycle T+2 at default).
REQ-023 SHALL, in RESPOND, hold rspN_valid high for the granted requester only, with rsp_data stable, until rspN_ready.
REQ-024 SHALL, on the response handshake edge, return to IDLE and increment conv_count, wrapping 0xFFFF to 0x0000.
REQ-025 SHALL accept no new request in the response handshake cycle; the next accept is no earlier than the following cycle.
REQ-026 The non-granted requester's rsp_valid SHALL stay 0; its rsp_ready SHALL be ignored.
REQ-027 Requests deasserted before acceptance SHALL be dropped silently; a request held while the block is busy SHALL be served later.

Reset
REQ-028 On rst, all outputs SHALL be 0 (busy, req/rsp valid and ready, rsp_data, conv_data_in, conv_to_float, grant_id, conv_count), state = IDLE, last_grant = 1 (req0 wins the first tie).
REQ-029 A reset during ISSUE or RESPOND SHALL abort the transaction with no response and no count increment.
REQ-030 A request that is valid in the reset cycle SHALL NOT be accepted in that cycle.

Verification
REQ-031 Single request: req0 0x00010000 with to_float=1, converter returns 0x3F800000 -> rsp0_valid high at T+2, rsp_data=0x3F800000, conv_count=1.
REQ-032 Tie: both requesters valid and held after reset -> grant order req0, req1, req0, req1, with each rsp on the matching port only.
REQ-033 Backpressure: rsp1_ready held low 10 cycles -> rsp1_valid and rsp_data stable, req0_ready=0, busy=1 throughout.
REQ-034 WAIT_CYC=3: conv_data_in is stable for 3 cycles, and the value returned in the last ISSUE cycle is the value captured.
REQ-035 Reset in ISSUE, then a new request -> no stale response, conv_count unchanged, and the new result is correct.
REQ-036 Wrap: preload conv_count to 0xFFFF via 65535 transactions, then complete one more -> conv_count = 0x0000.

Source files
------------

// File: rtl/number_convert_arbiter.sv
// Two-requester round-robin front end for a shared number converter.
// Holds each operand on the converter for WAIT_CYC cycles, then returns the result to its owner.
module number_convert_arbiter #(
   parameter int unsigned DATA_W   = 32,
   parameter int unsigned WAIT_CYC = 1
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              req0_valid,
   output logic              req0_ready,
   input  logic [DATA_W-1:0] req0_data,
   input  logic              req0_to_float,
   input  logic              req1_valid,
   output logic              req1_ready,
   input  logic [DATA_W-1:0] req1_data,
   input  logic              req1_to_float,
   output logic              rsp0_valid,
   input  logic              rsp0_ready,
   output logic              rsp1_valid,
   input  logic              rsp1_ready,
   output logic [DATA_W-1:0] rsp_data,
   output logic [DATA_W-1:0] conv_data_in,
   output logic              conv_to_float,
   input  logic [DATA_W-1:0] conv_data_out,
   output logic              busy,
   output logic              grant_id,
   output logic [15:0]       conv_count
);

   localparam int unsigned WAIT_EFF = (WAIT_CYC == 0) ? 1 : WAIT_CYC;
   localparam int unsigned WCNT_W   = (WAIT_EFF > 1) ? $clog2(WAIT_EFF) : 1;
   localparam int unsigned CNT_W    = 16;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      ISSUE   = 2'd1,
      RESPOND = 2'd2
   } state_t;

   state_t            state;
   state_t            state_nxt;
   logic              last_grant;
   logic [WCNT_W-1:0] wait_cnt;
   logic              win_id;
   logic              wait_last;
   logic              accept;
   logic              capture;
   logic              rsp_hs;

   // Round robin: a lone requester wins; on a tie the one not served last wins.
   assign win_id    = (req0_valid && req1_valid) ? ~last_grant : req1_valid;
   assign wait_last = (wait_cnt == WCNT_W'(WAIT_EFF - 1));

   always_ff @(posedge clk) begin
      if (rst) state <= IDLE;
      else     state <= state_nxt;
   end

   always_comb begin
      state_nxt  = state;
      req0_ready = 1'b0;
      req1_ready = 1'b0;
      accept     = 1'b0;
      capture    = 1'b0;
      rsp_hs     = 1'b0;
      case (state)
         IDLE: begin
            if (!rst && (req0_valid || req1_valid)) begin
               req0_ready = ~win_id;
               req1_ready = win_id;
               accept     = 1'b1;
               state_nxt  = ISSUE;
            end
         end
         ISSUE: begin
            if (wait_last) begin
               capture   = 1'b1;
               state_nxt = RESPOND;
            end
         end
         RESPOND: begin
            // Only the owner's ready closes the transaction.
            if (grant_id ? rsp1_ready : rsp0_ready) begin
               rsp_hs    = 1'b1;
               state_nxt = IDLE;
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         busy          <= 1'b0;
         last_grant    <= 1'b1;
         grant_id      <= 1'b0;
         wait_cnt      <= '0;
         conv_data_in  <= '0;
         conv_to_float <= 1'b0;
         rsp_data      <= '0;
         rsp0_valid    <= 1'b0;
         rsp1_valid    <= 1'b0;
         conv_count    <= '0;
      end else begin
         busy <= (state_nxt != IDLE);
         if (accept) begin
            conv_data_in  <= win_id ? req1_data : req0_data;
            conv_to_float <= win_id ? req1_to_float : req0_to_float;
            grant_id      <= win_id;
            last_grant    <= win_id;
            wait_cnt      <= '0;
         end else if (state == ISSUE) begin
            wait_cnt <= wait_cnt + WCNT_W'(1);
         end
         if (capture) begin
            rsp_data   <= conv_data_out;
            rsp0_valid <= ~grant_id;
            rsp1_valid <= grant_id;
         end else if (rsp_hs) begin
            rsp0_valid <= 1'b0;
            rsp1_valid <= 1'b0;
         end
         conv_count <= conv_count + CNT_W'(rsp_hs);
      end
   end

endmodule

// File: tb/tb_number_convert_arbiter.sv
// Bench for number_convert_arbiter: directed scenarios plus random traffic against a transaction-level model.
module tb_number_convert_arbiter;

   localparam int unsigned DW = 32;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic          rst;
   logic          req0_valid, req1_valid, req0_to_float, req1_to_float;
   logic [DW-1:0] req0_data, req1_data;
   logic          rsp0_ready, rsp1_ready;
   logic          req0_ready, req1_ready, rsp0_valid, rsp1_valid;
   logic [DW-1:0] rsp_data, conv_data_in, conv_data_out;
   logic          conv_to_float, busy, grant_id;
   logic [15:0]   conv_count;

   // WAIT_CYC=0 instance sharing the main inputs; it must behave like WAIT_CYC=1.
   logic          z_req0_ready, z_req1_ready, z_rsp0_valid, z_rsp1_valid;
   logic [DW-1:0] z_rsp_data, z_cin, z_cout;
   logic          z_ctf, z_busy, z_grant_id;
   logic [15:0]   z_conv_count;

   // WAIT_CYC=3 instance with its own requester 0.
   logic          t_req0_valid, t_req0_to_float, t_rsp0_ready;
   logic [DW-1:0] t_req0_data;
   logic          t_req0_ready, t_req1_ready, t_rsp0_valid, t_rsp1_valid;
   logic [DW-1:0] t_rsp_data, t_cin, t_cout;
   logic          t_ctf, t_busy, t_grant_id;
   logic [15:0]   t_conv_count;
   logic [31:0]   cyc = 32'd0;

   int n_tests = 0;
   int n_fail  = 0;

   // Stand-in converter: real Q16.16 -> float; a fixed bit scramble for the other direction.
   function automatic logic [31:0] conv_stub(input logic [31:0] x, input logic tf);
      real         r;
      logic [63:0] b;
      logic [10:0] e;
      if (!tf) return {x[15:0], x[31:16]} ^ 32'hDEAD_BEEF;
      if (x == 32'h0) return 32'h0;
      r = $itor($signed(x)) / 65536.0;
      b = $realtobits(r);
      e = b[62:52] - 11'd896;
      return {b[63], e[7:0], b[51:29]};
   endfunction

   assign conv_data_out = conv_stub(conv_data_in, conv_to_float);
   assign z_cout        = conv_stub(z_cin, z_ctf);
   assign t_cout        = conv_stub(t_cin, t_ctf) + cyc;
   always @(posedge clk) cyc <= cyc + 32'd1;

   number_convert_arbiter #(.DATA_W(DW), .WAIT_CYC(1)) dut (
      .clk(clk), .rst(rst),
      .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_data(req0_data), .req0_to_float(req0_to_float),
      .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_data(req1_data), .req1_to_float(req1_to_float),
      .rsp0_valid(rsp0_valid), .rsp0_ready(rsp0_ready), .rsp1_valid(rsp1_valid), .rsp1_ready(rsp1_ready),
      .rsp_data(rsp_data), .conv_data_in(conv_data_in), .conv_to_float(conv_to_float),
      .conv_data_out(conv_data_out), .busy(busy), .grant_id(grant_id), .conv_count(conv_count));

   number_convert_arbiter #(.DATA_W(DW), .WAIT_CYC(0)) dz (
      .clk(clk), .rst(rst),
      .req0_valid(req0_valid), .req0_ready(z_req0_ready), .req0_data(req0_data), .req0_to_float(req0_to_float),
      .req1_valid(req1_valid), .req1_ready(z_req1_ready), .req1_data(req1_data), .req1_to_float(req1_to_float),
      .rsp0_valid(z_rsp0_valid), .rsp0_ready(rsp0_ready), .rsp1_valid(z_rsp1_valid), .rsp1_ready(rsp1_ready),
      .rsp_data(z_rsp_data), .conv_data_in(z_cin), .conv_to_float(z_ctf),
      .conv_data_out(z_cout), .busy(z_busy), .grant_id(z_grant_id), .conv_count(z_conv_count));

   number_convert_arbiter #(.DATA_W(DW), .WAIT_CYC(3)) dut3 (
      .clk(clk), .rst(rst),
      .req0_valid(t_req0_valid), .req0_ready(t_req0_ready), .req0_data(t_req0_data), .req0_to_float(t_req0_to_float),
      .req1_valid(1'b0), .req1_ready(t_req1_ready), .req1_data('0), .req1_to_float(1'b0),
      .rsp0_valid(t_rsp0_valid), .rsp0_ready(t_rsp0_ready), .rsp1_valid(t_rsp1_valid), .rsp1_ready(1'b0),
      .rsp_data(t_rsp_data), .conv_data_in(t_cin), .conv_to_float(t_ctf),
      .conv_data_out(t_cout), .busy(t_busy), .grant_id(t_grant_id), .conv_count(t_conv_count));

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
      end
   endtask

   // Transaction-level reference state.
   bit          m_out, m_owner, m_last, m_gid, m_dir, m_rst_prev;
   int          m_acc, m_cyc, acc_id;
   logic [15:0] m_cnt, m_zcnt;
   logic [31:0] m_op, m_res;

   // One clock cycle: compare this cycle's outputs, advance the model, move to the next negedge.
   task automatic cycle();
      bit any, w, e_r0, e_r1, e_rv;
      #1;
      any  = !rst && !m_out && (req0_valid || req1_valid);
      w    = (req0_valid && req1_valid) ? !m_last : req1_valid;
      e_r0 = any && !w;
      e_r1 = any && w;
      e_rv = m_out && (m_cyc >= m_acc + 2);
      chk("req0_ready", 32'(req0_ready), 32'(e_r0));
      chk("req1_ready", 32'(req1_ready), 32'(e_r1));
      chk("busy", 32'(busy), 32'(m_out));
      chk("rsp0_valid", 32'(rsp0_valid), 32'(e_rv && !m_owner));
      chk("rsp1_valid", 32'(rsp1_valid), 32'(e_rv && m_owner));
      chk("grant_id", 32'(grant_id), 32'(m_gid));
      chk("conv_count", 32'(conv_count), 32'(m_cnt));
      chk("z_req0_ready", 32'(z_req0_ready), 32'(e_r0));
      chk("z_req1_ready", 32'(z_req1_ready), 32'(e_r1));
      chk("z_rsp0_valid", 32'(z_rsp0_valid), 32'(e_rv && !m_owner));
      chk("z_rsp1_valid", 32'(z_rsp1_valid), 32'(e_rv && m_owner));
      chk("z_busy", 32'(z_busy), 32'(m_out));
      chk("z_grant_id", 32'(z_grant_id), 32'(m_gid));
      chk("z_conv_count", 32'(z_conv_count), 32'(m_zcnt));
      if (e_rv) begin
         chk("rsp_data", rsp_data, m_res);
         chk("z_rsp_data", z_rsp_data, m_res);
      end
      if (m_out && !e_rv) begin
         chk("conv_data_in", conv_data_in, m_op);
         chk("conv_to_float", 32'(conv_to_float), 32'(m_dir));
      end
      if (m_rst_prev) begin
         chk("rst_rsp_data", rsp_data, 32'h0);
         chk("rst_conv_data_in", conv_data_in, 32'h0);
         chk("rst_conv_to_float", 32'(conv_to_float), 32'h0);
      end
      acc_id     = -1;
      m_rst_prev = rst;
      if (rst) begin
         m_out = 0; m_last = 1; m_gid = 0; m_cnt = '0; m_zcnt = '0;
      end else if (any) begin
         m_out = 1; m_owner = w; m_gid = w; m_last = w; m_acc = m_cyc;
         m_op  = w ? req1_data : req0_data;
         m_dir = w ? req1_to_float : req0_to_float;
         m_res = conv_stub(m_op, m_dir);
         acc_id = int'(w);
      end else if (e_rv && (m_owner ? rsp1_ready : rsp0_ready)) begin
         m_out  = 0;
         m_cnt  = m_cnt + 16'd1;
         m_zcnt = m_zcnt + 16'd1;
      end
      m_cyc++;
      @(negedge clk);
   endtask

   task automatic drain();
      req0_valid = 0; req1_valid = 0; rsp0_ready = 1; rsp1_ready = 1;
      for (int i = 0; i < 8; i++) cycle();
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   initial begin
      int          grants[$];
      int          exp_g[4];
      logic [31:0] d3, t0;
      logic        f3;
      exp_g = '{0, 1, 0, 1};
      m_out = 0; m_last = 1; m_gid = 0; m_cnt = '0; m_zcnt = '0; m_rst_prev = 0; m_cyc = 0;
      m_acc = 0; m_owner = 0; m_dir = 0; m_op = '0; m_res = '0; acc_id = -1;
      rst = 1;
      req0_valid = 1; req0_data = 32'h0001_0000; req0_to_float = 1;
      req1_valid = 0; req1_data = '0; req1_to_float = 0;
      rsp0_ready = 0; rsp1_ready = 0;
      t_req0_valid = 0; t_req0_data = '0; t_req0_to_float = 0; t_rsp0_ready = 0;
      @(negedge clk);

      // Reset with a pending request, then single request 1.0 -> float
      cycle(); cycle();
      rst = 0;
      cycle();
      chk("r31_accept", 32'(acc_id), 32'(0));
      req0_valid = 0;
      cycle();
      #1;
      chk("r31_rsp_valid", 32'(rsp0_valid), 32'h1);
      chk("r31_rsp_data", rsp_data, 32'h3F80_0000);
      rsp0_ready = 1;
      cycle();
      #1 chk("r31_count", 32'(conv_count), 32'h1);
      drain();

      // Tie after reset: grants alternate starting with req0
      rst = 1; cycle(); rst = 0;
      req0_valid = 1; req0_data = $urandom; req0_to_float = 0;
      req1_valid = 1; req1_data = $urandom; req1_to_float = 1;
      for (int i = 0; i < 20 && grants.size() < 4; i++) begin
         cycle();
         if (acc_id == 0) begin grants.push_back(0); req0_data = $urandom; end
         if (acc_id == 1) begin grants.push_back(1); req1_data = $urandom; end
      end
      chk("tie_grants", 32'(grants.size()), 32'd4);
      for (int i = 0; i < 4 && i < grants.size(); i++) chk("tie_order", 32'(grants[i]), 32'(exp_g[i]));
      drain();

      // Backpressure on requester 1 while requester 0 waits
      req1_valid = 1; req1_data = $urandom; req1_to_float = 0;
      rsp0_ready = 1; rsp1_ready = 0;
      cycle();
      chk("bp_accept", 32'(acc_id), 32'(1));
      req1_valid = 0;
      req0_valid = 1; req0_data = $urandom; req0_to_float = 1;
      for (int i = 0; i < 11; i++) cycle();
      rsp1_ready = 1;
      cycle();
      cycle();
      chk("bp_next_accept", 32'(acc_id), 32'(0));
      drain();

      // Reset while in ISSUE, then a fresh request
      req0_valid = 1; req0_data = $urandom; req0_to_float = 0;
      cycle();
      req0_valid = 0; rst = 1;
      cycle();
      rst = 0;
      for (int i = 0; i < 4; i++) cycle();
      #1 chk("r35_count_after_abort", 32'(conv_count), 32'h0);
      req1_valid = 1; req1_data = 32'hFFFE_8000; req1_to_float = 1;
      cycle();
      drain();
      #1 chk("r35_count_new", 32'(conv_count), 32'h1);

      // WAIT_CYC=3: operand held three cycles, last-cycle converter value captured
      d3 = $urandom; f3 = 1'($urandom_range(0, 1));
      t_req0_valid = 1; t_req0_data = d3; t_req0_to_float = f3;
      #1;
      chk("w3_ready", 32'(t_req0_ready), 32'h1);
      chk("w3_req1_ready", 32'(t_req1_ready), 32'h0);
      t0 = cyc;
      @(negedge clk);
      t_req0_valid = 0;
      for (int i = 0; i < 3; i++) begin
         #1;
         chk("w3_conv_in", t_cin, d3);
         chk("w3_busy", 32'(t_busy), 32'h1);
         chk("w3_rsp_early", 32'(t_rsp0_valid), 32'h0);
         @(negedge clk);
      end
      #1;
      chk("w3_rsp_valid", 32'(t_rsp0_valid), 32'h1);
      chk("w3_rsp1_valid", 32'(t_rsp1_valid), 32'h0);
      chk("w3_rsp_data", t_rsp_data, conv_stub(d3, f3) + t0 + 32'd3);
      chk("w3_grant", 32'(t_grant_id), 32'h0);
      t_rsp0_ready = 1;
      @(negedge clk);
      #1;
      chk("w3_rsp_done", 32'(t_rsp0_valid), 32'h0);
      chk("w3_count", 32'(t_conv_count), 32'h1);
      t_rsp0_ready = 0;
      @(negedge clk);

      // Random traffic with withdrawals, backpressure and occasional reset
      for (int k = 0; k < 400; k++) begin
         rst = ($urandom_range(0, 99) == 0);
         if (!req0_valid && $urandom_range(0, 2) == 0) begin
            req0_valid = 1; req0_data = $urandom; req0_to_float = 1'($urandom_range(0, 1));
         end else if (req0_valid && $urandom_range(0, 15) == 0) begin
            req0_valid = 0;
         end
         if (!req1_valid && $urandom_range(0, 2) == 0) begin
            req1_valid = 1; req1_data = $urandom; req1_to_float = 1'($urandom_range(0, 1));
         end else if (req1_valid && $urandom_range(0, 15) == 0) begin
            req1_valid = 0;
         end
         rsp0_ready = 1'($urandom_range(0, 1));
         rsp1_ready = 1'($urandom_range(0, 1));
         cycle();
         if (acc_id == 0) req0_valid = 0;
         if (acc_id == 1) req1_valid = 0;
      end
      rst = 0;
      drain();

      // Counter wrap: preload 0xFFFF, complete one more transaction
      force dut.conv_count = 16'hFFFF;
      m_cnt = 16'hFFFF;
      cycle();
      release dut.conv_count;
      cycle();
      req0_valid = 1; req0_data = $urandom; req0_to_float = 0;
      cycle();
      drain();
      #1 chk("wrap_count", 32'(conv_count), 32'h0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
